rs_wakeup_array: RTL and testbench

//  Reservation-station source-readiness tracker; consumer of scoreboard dispatch outputs (match/shift_r/delay).

---
 rtl/rs_wakeup_array_if.sv | 86 ++++++++
 rtl/rs_wakeup_array.sv | 238 +++++++++++++++++++++++
 tb/tb_rs_wakeup_array.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_wakeup_array_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : rs_wakeup_array_if                                 |
// | Description : Dispatch / broadcast / grant / status bundle for   |
// |               the reservation-station wakeup array.              |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
interface rs_wakeup_array_if #(
    parameter int ENTRIES     = 8,
    parameter int IDX_W       = 3,
    parameter int PHY_REG_SEL = 6,
    parameter int MAX_LATENCY = 4
);
    // dispatch slot 1
    logic                   alloc_1;
    logic [IDX_W-1:0]       alloc_idx_1;
    logic                   s1_val_1;
    logic [PHY_REG_SEL-1:0] s1_tag_1;
    logic                   s1_match_1;
    logic [MAX_LATENCY-1:0] s1_shift_1;
    logic [MAX_LATENCY-1:0] s1_delay_1;
    logic                   s2_val_1;
    logic [PHY_REG_SEL-1:0] s2_tag_1;
    logic                   s2_match_1;
    logic [MAX_LATENCY-1:0] s2_shift_1;
    logic [MAX_LATENCY-1:0] s2_delay_1;
    logic [PHY_REG_SEL-1:0] dst_1;
    logic                   wr_reg_1;
    // dispatch slot 2
    logic                   alloc_2;
    logic [IDX_W-1:0]       alloc_idx_2;
    logic                   s1_val_2;
    logic [PHY_REG_SEL-1:0] s1_tag_2;
    logic                   s1_match_2;
    logic [MAX_LATENCY-1:0] s1_shift_2;
    logic [MAX_LATENCY-1:0] s1_delay_2;
    logic                   s2_val_2;
    logic [PHY_REG_SEL-1:0] s2_tag_2;
    logic                   s2_match_2;
    logic [MAX_LATENCY-1:0] s2_shift_2;
    logic [MAX_LATENCY-1:0] s2_delay_2;
    logic [PHY_REG_SEL-1:0] dst_2;
    logic                   wr_reg_2;
    // tag broadcasts
    logic                   bc_valid_1;
    logic [PHY_REG_SEL-1:0] bc_dst_1;
    logic                   bc_valid_2;
    logic [PHY_REG_SEL-1:0] bc_dst_2;
    // select grants
    logic                   grant_1;
    logic [IDX_W-1:0]       grant_idx_1;
    logic                   grant_2;
    logic [IDX_W-1:0]       grant_idx_2;
    // status / results
    logic [ENTRIES-1:0]     req_vec;
    logic [ENTRIES-1:0]     busy_vec;
    logic [IDX_W:0]         free_cnt;
    logic                   issued_1;
    logic [PHY_REG_SEL-1:0] issued_dst_1;
    logic                   issued_2;
    logic [PHY_REG_SEL-1:0] issued_dst_2;
    logic                   alloc_err;

    modport master (
        output alloc_1, alloc_idx_1, s1_val_1, s1_tag_1, s1_match_1, s1_shift_1, s1_delay_1,
               s2_val_1, s2_tag_1, s2_match_1, s2_shift_1, s2_delay_1, dst_1, wr_reg_1,
               alloc_2, alloc_idx_2, s1_val_2, s1_tag_2, s1_match_2, s1_shift_2, s1_delay_2,
               s2_val_2, s2_tag_2, s2_match_2, s2_shift_2, s2_delay_2, dst_2, wr_reg_2,
               bc_valid_1, bc_dst_1, bc_valid_2, bc_dst_2,
               grant_1, grant_idx_1, grant_2, grant_idx_2,
        input  req_vec, busy_vec, free_cnt, issued_1, issued_dst_1, issued_2, issued_dst_2,
               alloc_err
    );

    modport slave (
        input  alloc_1, alloc_idx_1, s1_val_1, s1_tag_1, s1_match_1, s1_shift_1, s1_delay_1,
               s2_val_1, s2_tag_1, s2_match_1, s2_shift_1, s2_delay_1, dst_1, wr_reg_1,
               alloc_2, alloc_idx_2, s1_val_2, s1_tag_2, s1_match_2, s1_shift_2, s1_delay_2,
               s2_val_2, s2_tag_2, s2_match_2, s2_shift_2, s2_delay_2, dst_2, wr_reg_2,
               bc_valid_1, bc_dst_1, bc_valid_2, bc_dst_2,
               grant_1, grant_idx_1, grant_2, grant_idx_2,
        output req_vec, busy_vec, free_cnt, issued_1, issued_dst_1, issued_2, issued_dst_2,
               alloc_err
    );
endinterface
`default_nettype wire

// File: rtl/rs_wakeup_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : rs_wakeup_array                                    |
// | Description : Reservation-station source-readiness tracker.      |
// |               Snoops tag broadcasts, runs per-source latency     |
// |               shifters, raises issue requests, returns the       |
// |               granted destination tag as the next broadcast.     |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module rs_wakeup_array #(
    parameter int ENTRIES     = 8,
    parameter int IDX_W       = 3,
    parameter int PHY_REG_SEL = 6,
    parameter int MAX_LATENCY = 4
) (
    input  logic             clk,
    input  logic             reset,
    rs_wakeup_array_if.slave bus
);
    localparam int CNT_W = IDX_W + 1;

    // slot-indexed views of the dispatch/broadcast/grant inputs ([slot][source])
    logic [1:0]             w_alloc;
    logic [IDX_W-1:0]       w_alloc_idx [2];
    logic [1:0]             w_src_val   [2];
    logic [PHY_REG_SEL-1:0] w_src_tag   [2][2];
    logic [1:0]             w_src_match [2];
    logic [MAX_LATENCY-1:0] w_src_shift [2][2];
    logic [MAX_LATENCY-1:0] w_src_delay [2][2];
    logic [PHY_REG_SEL-1:0] w_dst       [2];
    logic [1:0]             w_wr_reg;
    logic [1:0]             w_bc_valid;
    logic [PHY_REG_SEL-1:0] w_bc_dst    [2];
    logic [1:0]             w_grant;
    logic [IDX_W-1:0]       w_grant_idx [2];

    assign w_alloc           = {bus.alloc_2, bus.alloc_1};
    assign w_alloc_idx[0]    = bus.alloc_idx_1;
    assign w_alloc_idx[1]    = bus.alloc_idx_2;
    assign w_src_val[0]      = {bus.s2_val_1, bus.s1_val_1};
    assign w_src_val[1]      = {bus.s2_val_2, bus.s1_val_2};
    assign w_src_tag[0][0]   = bus.s1_tag_1;
    assign w_src_tag[0][1]   = bus.s2_tag_1;
    assign w_src_tag[1][0]   = bus.s1_tag_2;
    assign w_src_tag[1][1]   = bus.s2_tag_2;
    assign w_src_match[0]    = {bus.s2_match_1, bus.s1_match_1};
    assign w_src_match[1]    = {bus.s2_match_2, bus.s1_match_2};
    assign w_src_shift[0][0] = bus.s1_shift_1;
    assign w_src_shift[0][1] = bus.s2_shift_1;
    assign w_src_shift[1][0] = bus.s1_shift_2;
    assign w_src_shift[1][1] = bus.s2_shift_2;
    assign w_src_delay[0][0] = bus.s1_delay_1;
    assign w_src_delay[0][1] = bus.s2_delay_1;
    assign w_src_delay[1][0] = bus.s1_delay_2;
    assign w_src_delay[1][1] = bus.s2_delay_2;
    assign w_dst[0]          = bus.dst_1;
    assign w_dst[1]          = bus.dst_2;
    assign w_wr_reg          = {bus.wr_reg_2, bus.wr_reg_1};
    assign w_bc_valid        = {bus.bc_valid_2, bus.bc_valid_1};
    assign w_bc_dst[0]       = bus.bc_dst_1;
    assign w_bc_dst[1]       = bus.bc_dst_2;
    assign w_grant           = {bus.grant_2, bus.grant_1};
    assign w_grant_idx[0]    = bus.grant_idx_1;
    assign w_grant_idx[1]    = bus.grant_idx_2;

    // entry storage
    logic [ENTRIES-1:0]     r_valid;
    logic [ENTRIES-1:0]     r_wr_reg;
    logic [PHY_REG_SEL-1:0] r_dst   [ENTRIES];
    logic [PHY_REG_SEL-1:0] r_tag   [ENTRIES][2];
    logic [1:0]             r_match [ENTRIES];
    logic [MAX_LATENCY-1:0] r_shift [ENTRIES][2];
    logic [MAX_LATENCY-1:0] r_delay [ENTRIES][2];
    logic [1:0]             r_issued;
    logic [PHY_REG_SEL-1:0] r_issued_dst [2];
    logic                   r_alloc_err;

    logic [1:0]             w_grant_hit;
    logic [ENTRIES-1:0]     w_freed;
    logic [ENTRIES-1:0]     w_busy_after;
    logic [1:0]             w_alloc_ok;
    logic                   w_alloc_err;
    logic [1:0]             w_new_match [2];
    logic [MAX_LATENCY-1:0] w_new_shift [2][2];
    logic [ENTRIES-1:0]     w_wr_en;
    logic [ENTRIES-1:0]     w_wr_slot;
    logic [1:0]             w_ent_hit [ENTRIES];
    logic [ENTRIES-1:0]     w_req;
    logic [CNT_W-1:0]       w_free_cnt;

    function automatic logic bc_match(input logic [1:0] v, input logic [PHY_REG_SEL-1:0] d0,
                                      input logic [PHY_REG_SEL-1:0] d1,
                                      input logic [PHY_REG_SEL-1:0] t);
        return (v[0] && (d0 == t)) || (v[1] && (d1 == t));
    endfunction

    // grants only count on valid entries; a granted entry is free before any alloc lands
    always_comb begin
        w_freed = '0;
        for (int k = 0; k < 2; k++) begin
            w_grant_hit[k] = w_grant[k] && r_valid[w_grant_idx[k]];
            if (w_grant_hit[k]) begin
                w_freed[w_grant_idx[k]] = 1'b1;
            end
        end
    end

    // allocation legality: busy target or slot-2 duplicate of slot-1 is dropped and flagged
    always_comb begin
        w_busy_after  = r_valid & ~w_freed;
        w_alloc_ok[0] = w_alloc[0] && !w_busy_after[w_alloc_idx[0]];
        w_alloc_ok[1] = w_alloc[1] && !(w_alloc[0] && (w_alloc_idx[1] == w_alloc_idx[0]))
                        && !w_busy_after[w_alloc_idx[1]];
        w_alloc_err   = (w_alloc[0] && !w_alloc_ok[0]) || (w_alloc[1] && !w_alloc_ok[1]);
    end

    // per-slot source image as written: no-source is ready, same-cycle broadcast folds in
    always_comb begin
        w_new_match[0] = '0;
        w_new_match[1] = '0;
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 2; s++) begin
                w_new_shift[k][s] = w_src_shift[k][s];
                if (!w_src_val[k][s]) begin
                    w_new_match[k][s] = 1'b1;
                    w_new_shift[k][s] = '1;
                end else if (!w_src_match[k][s] &&
                             bc_match(w_bc_valid, w_bc_dst[0], w_bc_dst[1], w_src_tag[k][s])) begin
                    w_new_match[k][s] = 1'b1;
                    w_new_shift[k][s] = w_src_delay[k][s];
                end else begin
                    w_new_match[k][s] = w_src_match[k][s];
                end
            end
        end
    end

    // per-entry write select and broadcast tag compare
    always_comb begin
        w_wr_en   = '0;
        w_wr_slot = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (w_alloc_ok[0] && (w_alloc_idx[0] == IDX_W'(e))) begin
                w_wr_en[e] = 1'b1;
            end else if (w_alloc_ok[1] && (w_alloc_idx[1] == IDX_W'(e))) begin
                w_wr_en[e]   = 1'b1;
                w_wr_slot[e] = 1'b1;
            end
            for (int s = 0; s < 2; s++) begin
                w_ent_hit[e][s] = bc_match(w_bc_valid, w_bc_dst[0], w_bc_dst[1], r_tag[e][s]);
            end
        end
    end

    // entry state: alloc beats grant-free beats broadcast beats shift
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid  <= '0;
            r_wr_reg <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                r_dst[e]   <= '0;
                r_match[e] <= '0;
                for (int s = 0; s < 2; s++) begin
                    r_tag[e][s]   <= '0;
                    r_shift[e][s] <= '0;
                    r_delay[e][s] <= '0;
                end
            end
        end else begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (w_wr_en[e]) begin
                    r_valid[e]  <= 1'b1;
                    r_wr_reg[e] <= w_wr_reg[w_wr_slot[e]];
                    r_dst[e]    <= w_dst[w_wr_slot[e]];
                    r_match[e]  <= w_new_match[w_wr_slot[e]];
                    for (int s = 0; s < 2; s++) begin
                        r_tag[e][s]   <= w_src_tag[w_wr_slot[e]][s];
                        r_delay[e][s] <= w_src_delay[w_wr_slot[e]][s];
                        r_shift[e][s] <= w_new_shift[w_wr_slot[e]][s];
                    end
                end else if (w_freed[e]) begin
                    r_valid[e] <= 1'b0;
                    r_match[e] <= '0;
                    for (int s = 0; s < 2; s++) begin
                        r_shift[e][s] <= '0;
                    end
                end else if (r_valid[e]) begin
                    for (int s = 0; s < 2; s++) begin
                        if (!r_match[e][s] && w_ent_hit[e][s]) begin
                            r_match[e][s] <= 1'b1;
                            r_shift[e][s] <= r_delay[e][s];
                        end else if (r_match[e][s] && !r_shift[e][s][0]) begin
                            r_shift[e][s] <= {r_shift[e][s][MAX_LATENCY-1],
                                              r_shift[e][s][MAX_LATENCY-1:1]};
                        end
                    end
                end
            end
        end
    end

    // registered issue results and allocation error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issued        <= '0;
            r_issued_dst[0] <= '0;
            r_issued_dst[1] <= '0;
            r_alloc_err     <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                r_issued[k] <= w_grant_hit[k] && r_wr_reg[w_grant_idx[k]];
                if (w_grant_hit[k]) begin
                    r_issued_dst[k] <= r_dst[w_grant_idx[k]];
                end
            end
            r_alloc_err <= w_alloc_err;
        end
    end

    // request vector and free-entry count straight from the registers
    always_comb begin
        w_free_cnt = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            w_req[e]   = r_valid[e] && r_shift[e][0][0] && r_shift[e][1][0];
            w_free_cnt = w_free_cnt + CNT_W'(!r_valid[e]);
        end
    end

    assign bus.req_vec      = w_req;
    assign bus.busy_vec     = r_valid;
    assign bus.free_cnt     = w_free_cnt;
    assign bus.issued_1     = r_issued[0];
    assign bus.issued_2     = r_issued[1];
    assign bus.issued_dst_1 = r_issued_dst[0];
    assign bus.issued_dst_2 = r_issued_dst[1];
    assign bus.alloc_err    = r_alloc_err;
endmodule
`default_nettype wire

// File: tb/tb_rs_wakeup_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_rs_wakeup_array                                 |
// | Description : Directed + random bench for rs_wakeup_array with a |
// |               countdown-based readiness reference model.         |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_rs_wakeup_array;
    localparam int ENTRIES = 8;
    localparam int IDX_W   = 3;
    localparam int PRS     = 6;
    localparam int ML      = 4;
    localparam int NEVER   = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rs_wakeup_array_if #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .PHY_REG_SEL(PRS), .MAX_LATENCY(ML)) bif ();

    rs_wakeup_array #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .PHY_REG_SEL(PRS), .MAX_LATENCY(ML)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int total = 0;
    int bad   = 0;

    // stimulus image, [slot][source]
    bit          a_en[2];
    int          a_idx[2];
    bit          a_val[2][2];
    logic [PRS-1:0] a_tag[2][2];
    bit          a_match[2][2];
    logic [ML-1:0] a_shift[2][2];
    logic [ML-1:0] a_delay[2][2];
    logic [PRS-1:0] a_dst[2];
    bit          a_wr[2];
    bit          b_v[2];
    logic [PRS-1:0] b_d[2];
    bit          g_v[2];
    int          g_i[2];

    // reference model: each source is waiting (-1) or counting edges down to ready (0)
    bit          m_valid[ENTRIES];
    bit          m_wr[ENTRIES];
    logic [PRS-1:0] m_dst[ENTRIES];
    int          m_cnt[ENTRIES][2];
    logic [PRS-1:0] m_tag[ENTRIES][2];
    logic [ML-1:0] m_delay[ENTRIES][2];
    bit          e_iss[2];
    logic [PRS-1:0] e_idst[2];
    bit          e_err;

    // edges until bit0 is set under sign-extending right shift = index of lowest set bit
    function automatic int edges_to_ready(logic [ML-1:0] v);
        for (int i = 0; i < ML; i++) if (v[i]) return i;
        return NEVER;
    endfunction

    function automatic bit bc_hit(logic [PRS-1:0] t);
        return (b_v[0] && b_d[0] == t) || (b_v[1] && b_d[1] == t);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            a_en[k] = 0; a_idx[k] = 0; a_dst[k] = '0; a_wr[k] = 0;
            b_v[k] = 0; b_d[k] = '0; g_v[k] = 0; g_i[k] = 0;
            for (int s = 0; s < 2; s++) begin
                a_val[k][s] = 0; a_tag[k][s] = '0; a_match[k][s] = 0;
                a_shift[k][s] = '0; a_delay[k][s] = '0;
            end
        end
    endtask

    task automatic set_alloc(int k, int idx, int dst, bit wr);
        a_en[k] = 1; a_idx[k] = idx; a_dst[k] = PRS'(dst); a_wr[k] = wr;
    endtask

    task automatic set_src(int k, int s, bit val, int tag, bit match, logic [ML-1:0] sh,
                           logic [ML-1:0] dly);
        a_val[k][s] = val; a_tag[k][s] = PRS'(tag); a_match[k][s] = match;
        a_shift[k][s] = sh; a_delay[k][s] = dly;
    endtask

    task automatic drive();
        bif.alloc_1 = a_en[0];            bif.alloc_2 = a_en[1];
        bif.alloc_idx_1 = IDX_W'(a_idx[0]); bif.alloc_idx_2 = IDX_W'(a_idx[1]);
        bif.s1_val_1 = a_val[0][0];  bif.s1_tag_1 = a_tag[0][0];  bif.s1_match_1 = a_match[0][0];
        bif.s1_shift_1 = a_shift[0][0]; bif.s1_delay_1 = a_delay[0][0];
        bif.s2_val_1 = a_val[0][1];  bif.s2_tag_1 = a_tag[0][1];  bif.s2_match_1 = a_match[0][1];
        bif.s2_shift_1 = a_shift[0][1]; bif.s2_delay_1 = a_delay[0][1];
        bif.s1_val_2 = a_val[1][0];  bif.s1_tag_2 = a_tag[1][0];  bif.s1_match_2 = a_match[1][0];
        bif.s1_shift_2 = a_shift[1][0]; bif.s1_delay_2 = a_delay[1][0];
        bif.s2_val_2 = a_val[1][1];  bif.s2_tag_2 = a_tag[1][1];  bif.s2_match_2 = a_match[1][1];
        bif.s2_shift_2 = a_shift[1][1]; bif.s2_delay_2 = a_delay[1][1];
        bif.dst_1 = a_dst[0]; bif.wr_reg_1 = a_wr[0];
        bif.dst_2 = a_dst[1]; bif.wr_reg_2 = a_wr[1];
        bif.bc_valid_1 = b_v[0]; bif.bc_dst_1 = b_d[0];
        bif.bc_valid_2 = b_v[1]; bif.bc_dst_2 = b_d[1];
        bif.grant_1 = g_v[0]; bif.grant_idx_1 = IDX_W'(g_i[0]);
        bif.grant_2 = g_v[1]; bif.grant_idx_2 = IDX_W'(g_i[1]);
    endtask

    task automatic model_reset();
        for (int e = 0; e < ENTRIES; e++) begin
            m_valid[e] = 0; m_wr[e] = 0; m_dst[e] = '0;
            for (int s = 0; s < 2; s++) begin
                m_cnt[e][s] = -1; m_tag[e][s] = '0; m_delay[e][s] = '0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            e_iss[k] = 0; e_idst[k] = '0;
        end
        e_err = 0;
    endtask

    task automatic check_all();
        logic [ENTRIES-1:0] er;
        logic [ENTRIES-1:0] eb;
        int ef;
        ef = 0;
        for (int e = 0; e < ENTRIES; e++) begin
            eb[e] = m_valid[e];
            er[e] = m_valid[e] && m_cnt[e][0] == 0 && m_cnt[e][1] == 0;
            if (!m_valid[e]) ef++;
        end
        chk("req_vec",  32'(bif.req_vec),  32'(er));
        chk("busy_vec", 32'(bif.busy_vec), 32'(eb));
        chk("free_cnt", 32'(bif.free_cnt), 32'(ef));
        chk("issued_1", 32'(bif.issued_1), 32'(e_iss[0]));
        chk("issued_2", 32'(bif.issued_2), 32'(e_iss[1]));
        if (e_iss[0]) chk("issued_dst_1", 32'(bif.issued_dst_1), 32'(e_idst[0]));
        if (e_iss[1]) chk("issued_dst_2", 32'(bif.issued_dst_2), 32'(e_idst[1]));
        chk("alloc_err", 32'(bif.alloc_err), 32'(e_err));
    endtask

    // apply current stimulus for one edge, advance the model, compare after the edge
    task automatic step();
        bit hit[2];
        bit freed[ENTRIES];
        bit busy_a[ENTRIES];
        bit ok[2];
        int e;
        drive();
        for (int i = 0; i < ENTRIES; i++) freed[i] = 0;
        for (int k = 0; k < 2; k++) begin
            hit[k]   = g_v[k] && m_valid[g_i[k]];
            e_iss[k] = hit[k] && m_wr[g_i[k]];
            if (hit[k]) begin
                e_idst[k] = m_dst[g_i[k]];
                freed[g_i[k]] = 1;
            end
        end
        for (int i = 0; i < ENTRIES; i++) busy_a[i] = m_valid[i] && !freed[i];
        ok[0] = a_en[0] && !busy_a[a_idx[0]];
        ok[1] = a_en[1] && !(a_en[0] && a_idx[1] == a_idx[0]) && !busy_a[a_idx[1]];
        e_err = (a_en[0] && !ok[0]) || (a_en[1] && !ok[1]);
        for (int i = 0; i < ENTRIES; i++) begin
            if (freed[i]) m_valid[i] = 0;
            else if (m_valid[i]) begin
                for (int s = 0; s < 2; s++) begin
                    if (m_cnt[i][s] == -1) begin
                        if (bc_hit(m_tag[i][s])) m_cnt[i][s] = edges_to_ready(m_delay[i][s]);
                    end else if (m_cnt[i][s] > 0 && m_cnt[i][s] < NEVER) begin
                        m_cnt[i][s]--;
                    end
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (ok[k]) begin
                e = a_idx[k];
                m_valid[e] = 1; m_wr[e] = a_wr[k]; m_dst[e] = a_dst[k];
                for (int s = 0; s < 2; s++) begin
                    m_tag[e][s] = a_tag[k][s]; m_delay[e][s] = a_delay[k][s];
                    if (!a_val[k][s])            m_cnt[e][s] = 0;
                    else if (a_match[k][s])      m_cnt[e][s] = edges_to_ready(a_shift[k][s]);
                    else if (bc_hit(a_tag[k][s])) m_cnt[e][s] = edges_to_ready(a_delay[k][s]);
                    else                         m_cnt[e][s] = -1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [ML-1:0] dly_tab [3];
        int            lat_tab [3];
        logic [ML-1:0] sh_tab  [4];
        dly_tab = '{4'b1111, 4'b1100, 4'b1000};
        lat_tab = '{1, 3, 4};
        sh_tab  = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};

        // reset state
        reset = 1'b0;
        idle();
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_free_cnt", 32'(bif.free_cnt), 32'(ENTRIES));
        reset = 1'b1;

        // wakeup latency for ALU / MUL / LDST delay encodings
        for (int d = 0; d < 3; d++) begin
            idle(); set_alloc(0, 0, 9, 1); set_src(0, 0, 1, 5, 0, 4'b0000, dly_tab[d]);
            step();
            chk("lat_alloc_req0", 32'(bif.req_vec[0]), 32'(0));
            idle(); step();
            idle(); b_v[0] = 1; b_d[0] = 6'd5; step();
            chk("lat_bc_req0", 32'(bif.req_vec[0]), 32'(lat_tab[d] == 1));
            idle();
            for (int j = 2; j <= lat_tab[d]; j++) begin
                step();
                chk("lat_req0", 32'(bif.req_vec[0]), 32'(j == lat_tab[d]));
            end
            idle(); g_v[0] = 1; g_i[0] = 0; step();
            chk("grant_issued_1", 32'(bif.issued_1), 32'(1));
            chk("grant_issued_dst_1", 32'(bif.issued_dst_1), 32'(9));
            chk("grant_free_cnt", 32'(bif.free_cnt), 32'(ENTRIES));
        end

        // allocation folded with same-cycle broadcast on slot 2
        idle(); set_alloc(0, 1, 14, 0); set_src(0, 0, 1, 7, 0, 4'b0000, 4'b1111);
        b_v[1] = 1; b_d[1] = 6'd7; step();
        chk("fold_req1", 32'(bif.req_vec[1]), 32'(1));
        idle(); g_v[1] = 1; g_i[1] = 1; step();       // wr_reg=0: no issue pulse
        idle(); g_v[0] = 1; g_i[0] = 1; step();       // invalid entry
        chk("grant_invalid", 32'(bif.issued_1), 32'(0));

        // duplicate index and busy-index allocation
        idle(); set_alloc(0, 3, 12, 1); set_alloc(1, 3, 13, 1);
        set_src(1, 0, 1, 2, 0, 4'b0000, 4'b1111); step();
        chk("dup_err", 32'(bif.alloc_err), 32'(1));
        idle(); step();
        idle(); set_alloc(0, 3, 20, 0); set_src(0, 0, 1, 2, 0, 4'b0000, 4'b1000); step();
        chk("busy_err", 32'(bif.alloc_err), 32'(1));
        chk("busy_req3", 32'(bif.req_vec[3]), 32'(1));

        // grant and alloc to the same index in one edge, then grant racing broadcast
        idle(); g_v[0] = 1; g_i[0] = 3; set_alloc(1, 3, 21, 1);
        set_src(1, 0, 1, 9, 0, 4'b0000, 4'b1111); step();
        chk("ga_busy3", 32'(bif.busy_vec[3]), 32'(1));
        idle(); g_v[1] = 1; g_i[1] = 3; b_v[0] = 1; b_d[0] = 6'd9; step();
        chk("gb_issued_dst_2", 32'(bif.issued_dst_2), 32'(21));

        // fill every entry, overflow, start countdowns, then reset mid-flight
        for (int p = 0; p < ENTRIES / 2; p++) begin
            idle();
            for (int k = 0; k < 2; k++) begin
                set_alloc(k, 2 * p + k, 2 * p + k + 1, 1);
                set_src(k, 0, 1, 10 + 2 * p + k, 0, 4'b0000, 4'b1000);
            end
            step();
        end
        chk("full_free_cnt", 32'(bif.free_cnt), 32'(0));
        idle(); set_alloc(0, 5, 1, 1); step();
        chk("full_err", 32'(bif.alloc_err), 32'(1));
        idle(); b_v[0] = 1; b_d[0] = 6'd10; b_v[1] = 1; b_d[1] = 6'd11; step();
        idle(); step();
        drive();
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        g_v[0] = 1; g_i[0] = 0; drive();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        idle(); drive();
        #2;
        reset = 1'b1;
        step();
        chk("post_rst_issued_1", 32'(bif.issued_1), 32'(0));
        chk("post_rst_free_cnt", 32'(bif.free_cnt), 32'(ENTRIES));

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    set_alloc(k, int'($urandom_range(0, ENTRIES - 1)), int'($urandom_range(0, 63)),
                              1'($urandom_range(0, 1)));
                    for (int s = 0; s < 2; s++) begin
                        bit v;
                        bit m;
                        v = ($urandom_range(0, 3) != 0);
                        m = ($urandom_range(0, 3) == 0);
                        set_src(k, s, v, int'($urandom_range(0, 7)), m,
                                m ? sh_tab[$urandom_range(0, 3)] : 4'b0000,
                                dly_tab[$urandom_range(0, 2)]);
                    end
                end
                b_v[k] = 1'($urandom_range(0, 1));
                b_d[k] = PRS'($urandom_range(0, 7));
                g_v[k] = ($urandom_range(0, 2) == 0);
                g_i[k] = int'($urandom_range(0, ENTRIES - 1));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
